// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub arbiter slice.
package fp_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int SIGN_BIT = 31;

  typedef logic [FP_W-1:0] fp_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  function automatic fp_word_t flip_sign(input fp_word_t v, input logic neg);
    return {v[SIGN_BIT] ^ neg, v[SIGN_BIT-1:0]};
  endfunction

  function automatic logic [EXP_MSB-EXP_LSB:0] exp_field(input fp_word_t v);
    return v[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first pending request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  int idx;

  // Scan farthest-to-nearest so the nearest pending request overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one combinational FP add/sub unit among NREQ requesters with
// round-robin arbitration and a single id-tagged response channel.
module fp_addsub_arbiter
  import fp_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DP_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FP_W-1:0]     req_op1,
  input  logic [NREQ*FP_W-1:0]     req_op2,
  input  logic [NREQ-1:0]          req_sub,
  output logic [FP_W-1:0]          dp_op1,
  output logic [FP_W-1:0]          dp_op2,
  input  logic [FP_W-1:0]          dp_result,
  input  logic                     dp_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [FP_W-1:0]          rsp_result,
  output logic                     rsp_overflow,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int WAIT_W = $clog2(DP_LAT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  id;
  logic [WAIT_W-1:0] wait_cnt;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  next_ptr;
  fp_word_t          op1_sel;
  fp_word_t          op2_sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign op1_sel  = req_op1[int'(grant_idx)*FP_W +: FP_W];
  assign op2_sel  = req_op2[int'(grant_idx)*FP_W +: FP_W];
  assign next_ptr = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id           <= '0;
      wait_cnt     <= '0;
      dp_op1       <= '0;
      dp_op2       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            dp_op1   <= op1_sel;
            dp_op2   <= flip_sign(op2_sel, req_sub[grant_idx]);
            id       <= grant_idx;
            rr_ptr   <= next_ptr;
            wait_cnt <= WAIT_W'(DP_LAT);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt - 1'b1;
          // Operands have been stable for DP_LAT cycles once the count reaches 1.
          if (wait_cnt == WAIT_W'(1)) begin
            rsp_result   <= dp_result;
            rsp_overflow <= dp_overflow;
            rsp_id       <= id;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench: a main instance (defaults) plus a CNT_W=2 instance sharing stimulus.
module tb_fp_addsub_arbiter;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [3:0]    req_valid;
  logic [127:0]  req_op1, req_op2;
  logic [3:0]    req_sub;
  logic          rsp_ready;

  logic [3:0]    req_ready, req_ready_s;
  logic [31:0]   dp_op1, dp_op2, dp_op1_s, dp_op2_s;
  logic [31:0]   dp_result, dp_result_s;
  logic          dp_overflow, dp_overflow_s;
  logic          rsp_valid, rsp_valid_s;
  logic [1:0]    rsp_id, rsp_id_s;
  logic [31:0]   rsp_result, rsp_result_s;
  logic          rsp_overflow, rsp_overflow_s;
  logic          busy, busy_s;
  logic [15:0]   op_count;
  logic [1:0]    op_count_s;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in datapath: exact sums for the directed FP cases, a distinctive mix otherwise.
  function automatic logic [31:0] fake_dp(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4020_0000) return 32'h4080_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  assign dp_result     = fake_dp(dp_op1, dp_op2);
  assign dp_overflow   = (dp_op1[30:23] == 8'hFF);
  assign dp_result_s   = fake_dp(dp_op1_s, dp_op2_s);
  assign dp_overflow_s = (dp_op1_s[30:23] == 8'hFF);

  fp_addsub_arbiter dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_result(dp_result), .dp_overflow(dp_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .busy(busy), .op_count(op_count)
  );

  fp_addsub_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub),
    .dp_op1(dp_op1_s), .dp_op2(dp_op2_s), .dp_result(dp_result_s), .dp_overflow(dp_overflow_s),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s),
    .rsp_result(rsp_result_s), .rsp_overflow(rsp_overflow_s), .busy(busy_s), .op_count(op_count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] op1_i, op2_i, exp_op2;
    logic        sub_i;
    int          exp_id, last_cyc;

    n_rst = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; req_sub = '0; rsp_ready = 1'b0;
    tick(); tick();
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("rst_op_count",  32'(op_count),   32'd0);
    check("rst_dp_op1",    dp_op1,          32'd0);
    check("rst_dp_op2",    dp_op2,          32'd0);
    check("rst_rsp_res",   rsp_result,      32'd0);
    check("rst_req_ready", 32'(req_ready),  32'd0);
    n_rst = 1'b1;

    // Add, requester 0
    req_op1[31:0] = 32'h3FC0_0000; req_op2[31:0] = 32'h4020_0000; req_sub = 4'b0000;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    check("add_ready", 32'(req_ready), 32'h1);
    tick();
    check("add_ready_drop", 32'(req_ready), 32'h0);
    check("add_busy",       32'(busy),      32'd1);
    check("add_vld_issue",  32'(rsp_valid), 32'd0);
    check("add_dp_op1",     dp_op1,         32'h3FC0_0000);
    check("add_dp_op2",     dp_op2,         32'h4020_0000);
    req_valid = 4'b0000;
    tick();
    check("add_vld",    32'(rsp_valid), 32'd1);
    check("add_result", rsp_result,     32'h4080_0000);
    check("add_id",     32'(rsp_id),    32'd0);
    check("add_ovf",    32'(rsp_overflow), 32'd0);
    check("add_cnt_pre", 32'(op_count), 32'd0);
    tick();
    check("add_vld_done", 32'(rsp_valid), 32'd0);
    check("add_cnt",      32'(op_count),  32'd1);
    check("add_idle",     32'(busy),      32'd0);

    // Subtract, requester 2, then 5 cycles of backpressure
    req_op1[95:64] = 32'h4040_0000; req_op2[95:64] = 32'h3F80_0000; req_sub = 4'b0100;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    check("sub_ready", 32'(req_ready), 32'h4);
    tick();
    check("sub_dp_op2", dp_op2, 32'hBF80_0000);
    req_valid = 4'b1111;
    tick();
    check("sub_vld",    32'(rsp_valid), 32'd1);
    check("sub_result", rsp_result,     32'h4000_0000);
    check("sub_id",     32'(rsp_id),    32'd2);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_vld",    32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result,     32'h4000_0000);
      check("bp_id",     32'(rsp_id),    32'd2);
      check("bp_ready",  32'(req_ready), 32'h0);
      check("bp_cnt",    32'(op_count),  32'd1);
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    tick();
    check("bp_vld_done", 32'(rsp_valid),  32'd0);
    check("bp_cnt_done", 32'(op_count),   32'd2);
    check("bp_sat_cnt",  32'(op_count_s), 32'd2);
    check("idle_hold",   dp_op2,          32'hBF80_0000);

    // Reset during ISSUE; rr_ptr is 3 so requester 1 wins
    req_op1[63:32] = 32'h1234_5678; req_op2[63:32] = 32'h0BAD_F00D; req_sub = 4'b0000;
    req_valid = 4'b0010;
    #1;
    check("mid_ready", 32'(req_ready), 32'h2);
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("mid_rst_busy", 32'(busy),      32'd0);
    check("mid_rst_vld",  32'(rsp_valid), 32'd0);
    check("mid_rst_cnt",  32'(op_count),  32'd0);
    check("mid_rst_op1",  dp_op1,         32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Round-robin with all requesters pending; also drives the CNT_W=2 instance into saturation
    for (int i = 0; i < 4; i++) begin
      req_op1[32*i +: 32] = (i == 3) ? 32'h7F80_0000 : 32'h4100_0000 + 32'(i);
      req_op2[32*i +: 32] = 32'h4000_0000 | (32'(i) << 4);
      req_sub[i]          = (i % 2 == 1);
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    last_cyc = cyc;
    for (int k = 0; k < 6; k++) begin
      exp_id  = k % 4;
      op1_i   = req_op1[32*exp_id +: 32];
      op2_i   = req_op2[32*exp_id +: 32];
      sub_i   = req_sub[exp_id];
      exp_op2 = {op2_i[31] ^ sub_i, op2_i[30:0]};
      check("rr_grant", 32'(req_ready), 32'(1) << exp_id);
      if (k > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
      tick();
      check("rr_dp_op1", dp_op1, op1_i);
      check("rr_dp_op2", dp_op2, exp_op2);
      tick();
      check("rr_vld",    32'(rsp_valid),    32'd1);
      check("rr_id",     32'(rsp_id),       32'(exp_id));
      check("rr_result", rsp_result,        fake_dp(op1_i, exp_op2));
      check("rr_ovf",    32'(rsp_overflow), (exp_id == 3) ? 32'd1 : 32'd0);
      tick();
      check("rr_cnt",     32'(op_count),   32'(k + 1));
      check("sat_cnt",    32'(op_count_s), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end
    req_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
